// File: rtl/spio_status_led_shifter_if.sv
// Signal bundle between the status LED source and the serial LED shifter.
// The shifter takes the slave side; whatever supplies LED state takes master.
interface spio_status_led_shifter_if #(
  parameter int NUM_DEVICES = 8
);
  logic [NUM_DEVICES-1:0] LED_IN;
  logic                   ENABLE_IN;
  logic                   SCLK_OUT;
  logic                   SDATA_OUT;
  logic                   LATCH_OUT;
  logic                   BUSY_OUT;
  logic                   FRAME_DONE_OUT;

  modport master (
    output LED_IN, ENABLE_IN,
    input  SCLK_OUT, SDATA_OUT, LATCH_OUT, BUSY_OUT, FRAME_DONE_OUT
  );

  modport slave (
    input  LED_IN, ENABLE_IN,
    output SCLK_OUT, SDATA_OUT, LATCH_OUT, BUSY_OUT, FRAME_DONE_OUT
  );
endinterface

// File: rtl/spio_status_led_shifter.sv
// Serialises a snapshot of the status LEDs MSB-first into an external
// shift-register chain, then strobes the storage latch; all outputs registered.
module spio_status_led_shifter #(
  parameter int NUM_DEVICES  = 8,
  parameter int HALF_PERIOD  = 4,
  parameter int LATCH_CYCLES = 2,
  parameter bit INVERT       = 1'b0
) (
  input  logic CLK_IN,
  input  logic RESET_IN,
  spio_status_led_shifter_if.slave bus
);

  localparam int PH_W  = $clog2(HALF_PERIOD + 1);
  localparam int BIT_W = $clog2(NUM_DEVICES + 1);
  localparam int LT_W  = $clog2(LATCH_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_DEVICES - 1);
  localparam logic [LT_W-1:0]  LT_LAST  = LT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_LOW  = 2'd1,
    SHIFT_HIGH = 2'd2,
    LATCH      = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [PH_W-1:0]        phase, phase_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [LT_W-1:0]        lat_cnt, lat_cnt_nxt;
  logic [NUM_DEVICES-1:0] shreg, shreg_nxt;

  logic sclk_q, sdata_q, latch_q, busy_q, done_q;
  logic sclk_nxt, sdata_nxt, latch_nxt, busy_nxt, done_nxt;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_cnt_nxt = bit_cnt;
    lat_cnt_nxt = lat_cnt;
    shreg_nxt   = shreg;

    case (state)
      IDLE: begin
        if (bus.ENABLE_IN) begin
          shreg_nxt   = bus.LED_IN ^ {NUM_DEVICES{INVERT}};
          phase_nxt   = '0;
          bit_cnt_nxt = '0;
          lat_cnt_nxt = '0;
          state_nxt   = SHIFT_LOW;
        end
      end

      SHIFT_LOW: begin
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          state_nxt = SHIFT_HIGH;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end

      SHIFT_HIGH: begin
        if (phase == PH_LAST) begin
          phase_nxt   = '0;
          bit_cnt_nxt = bit_cnt + 1'b1;
          shreg_nxt   = shreg << 1;
          state_nxt   = (bit_cnt == BIT_LAST) ? LATCH : SHIFT_LOW;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end

      LATCH: begin
        if (lat_cnt == LT_LAST) begin
          lat_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe, without an extra cycle of lag.
    sclk_nxt  = (state_nxt == SHIFT_HIGH);
    latch_nxt = (state_nxt == LATCH);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state == LATCH) && (state_nxt == IDLE);
    sdata_nxt = 1'b0;
    if ((state_nxt == SHIFT_LOW) || (state_nxt == SHIFT_HIGH))
      sdata_nxt = shreg_nxt[NUM_DEVICES-1];
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_cnt_nxt;
      lat_cnt <= lat_cnt_nxt;
      shreg   <= shreg_nxt;
      sclk_q  <= sclk_nxt;
      sdata_q <= sdata_nxt;
      latch_q <= latch_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.SCLK_OUT       = sclk_q;
  assign bus.SDATA_OUT      = sdata_q;
  assign bus.LATCH_OUT      = latch_q;
  assign bus.BUSY_OUT       = busy_q;
  assign bus.FRAME_DONE_OUT = done_q;

endmodule

// File: tb/tb_spio_status_led_shifter.sv
// Directed bench for the LED shifter: default, inverted and minimal-size
// instances share clock, reset and enable; one instance is observed per step.
module tb_spio_status_led_shifter;

  logic clk;
  logic rst;

  int nchk  = 0;
  int npass = 0;

  logic [15:0] bits;
  int          nbits, busy_cnt, latch_cnt, done_cnt;
  int          done_t[$];
  logic [7:0]  sclk_hist;
  logic        prev_sclk;

  spio_status_led_shifter_if #(.NUM_DEVICES(8)) if_a ();
  spio_status_led_shifter_if #(.NUM_DEVICES(8)) if_b ();
  spio_status_led_shifter_if #(.NUM_DEVICES(1)) if_c ();

  spio_status_led_shifter #(
    .NUM_DEVICES(8), .HALF_PERIOD(4), .LATCH_CYCLES(2), .INVERT(1'b0)
  ) dut_a (.CLK_IN(clk), .RESET_IN(rst), .bus(if_a.slave));

  spio_status_led_shifter #(
    .NUM_DEVICES(8), .HALF_PERIOD(4), .LATCH_CYCLES(2), .INVERT(1'b1)
  ) dut_b (.CLK_IN(clk), .RESET_IN(rst), .bus(if_b.slave));

  spio_status_led_shifter #(
    .NUM_DEVICES(1), .HALF_PERIOD(1), .LATCH_CYCLES(1), .INVERT(1'b0)
  ) dut_c (.CLK_IN(clk), .RESET_IN(rst), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_en(input logic v);
    if_a.ENABLE_IN = v;
    if_b.ENABLE_IN = v;
    if_c.ENABLE_IN = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Observe one instance for n cycles; drop enable after sample en_cycles and
  // load chg_val into instance A's LEDs after sample chg_cyc.
  task automatic mon(input int which, input int n, input int en_cycles,
                     input int chg_cyc, input logic [7:0] chg_val);
    logic s_sclk, s_sdata, s_busy, s_latch, s_done;
    bits = '0; nbits = 0; busy_cnt = 0; latch_cnt = 0; done_cnt = 0;
    done_t.delete(); sclk_hist = '0; prev_sclk = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      case (which)
        0: {s_sclk, s_sdata, s_busy, s_latch, s_done} = {if_a.SCLK_OUT,
             if_a.SDATA_OUT, if_a.BUSY_OUT, if_a.LATCH_OUT, if_a.FRAME_DONE_OUT};
        1: {s_sclk, s_sdata, s_busy, s_latch, s_done} = {if_b.SCLK_OUT,
             if_b.SDATA_OUT, if_b.BUSY_OUT, if_b.LATCH_OUT, if_b.FRAME_DONE_OUT};
        default: {s_sclk, s_sdata, s_busy, s_latch, s_done} = {if_c.SCLK_OUT,
             if_c.SDATA_OUT, if_c.BUSY_OUT, if_c.LATCH_OUT, if_c.FRAME_DONE_OUT};
      endcase
      if (s_sclk && !prev_sclk) begin
        bits = {bits[14:0], s_sdata};
        nbits++;
      end
      prev_sclk = s_sclk;
      if (s_busy) begin
        busy_cnt++;
        sclk_hist = {sclk_hist[6:0], s_sclk};
      end
      if (s_latch) latch_cnt++;
      if (s_done) begin
        done_cnt++;
        done_t.push_back(k);
      end
      if (k == en_cycles) set_en(1'b0);
      if (k == chg_cyc) if_a.LED_IN = chg_val;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_en(1'b0);
    if_a.LED_IN = 8'hA5;
    if_b.LED_IN = 8'hFF;
    if_c.LED_IN = 1'b1;
    idle(3);

    // Reset state
    check("rst_sclk",  int'(if_a.SCLK_OUT), 0);
    check("rst_sdata", int'(if_a.SDATA_OUT), 0);
    check("rst_latch", int'(if_a.LATCH_OUT), 0);
    check("rst_busy",  int'(if_a.BUSY_OUT), 0);
    check("rst_done",  int'(if_a.FRAME_DONE_OUT), 0);
    rst = 1'b0;
    mon(0, 10, 0, 0, 8'h00);
    check("idle_no_busy", busy_cnt, 0);

    // Single frame of 8'hA5 with a one-cycle enable pulse
    set_en(1'b1);
    mon(0, 80, 1, 0, 8'h00);
    check("a5_bits",  int'(bits[7:0]), 'hA5);
    check("a5_nbits", nbits, 8);
    check("a5_busy",  busy_cnt, 66);
    check("a5_latch", latch_cnt, 2);
    check("a5_done",  done_cnt, 1);
    check("a5_done_t", (done_t.size() > 0) ? done_t[0] : -1, 67);

    // Enable held high across three frames
    idle(5);
    set_en(1'b1);
    mon(0, 201, 201, 0, 8'h00);
    check("rep_busy", busy_cnt, 198);
    check("rep_done", done_cnt, 3);
    check("rep_gap1", (done_t.size() > 2) ? done_t[1] - done_t[0] : -1, 67);
    check("rep_gap2", (done_t.size() > 2) ? done_t[2] - done_t[1] : -1, 67);
    check("rep_latch", latch_cnt, 6);

    // Inverted drive
    idle(80);
    set_en(1'b1);
    mon(1, 80, 1, 0, 8'h00);
    check("inv_bits",  int'(bits[7:0]), 0);
    check("inv_nbits", nbits, 8);
    check("inv_busy",  busy_cnt, 66);

    // LED change during bit 3 lands only in the following frame
    idle(80);
    if_a.LED_IN = 8'h00;
    set_en(1'b1);
    mon(0, 140, 68, 28, 8'hFF);
    check("snap_bits",  int'(bits), 'h00FF);
    check("snap_nbits", nbits, 16);
    check("snap_done",  done_cnt, 2);
    check("snap_busy",  busy_cnt, 132);

    // Reset during bit 5 abandons the frame
    idle(80);
    if_a.LED_IN = 8'hA5;
    set_en(1'b1);
    mon(0, 44, 1, 0, 8'h00);
    check("mid_busy_before", busy_cnt, 44);
    check("mid_sdata_before", int'(if_a.SDATA_OUT), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_sclk",  int'(if_a.SCLK_OUT), 0);
    check("mid_rst_sdata", int'(if_a.SDATA_OUT), 0);
    check("mid_rst_latch", int'(if_a.LATCH_OUT), 0);
    check("mid_rst_busy",  int'(if_a.BUSY_OUT), 0);
    check("mid_rst_done",  int'(if_a.FRAME_DONE_OUT), 0);
    idle(2);
    rst = 1'b0;
    mon(0, 20, 0, 0, 8'h00);
    check("post_rst_latch", latch_cnt, 0);
    check("post_rst_done",  done_cnt, 0);
    check("post_rst_busy",  busy_cnt, 0);
    set_en(1'b1);
    mon(0, 80, 1, 0, 8'h00);
    check("restart_bits", int'(bits[7:0]), 'hA5);
    check("restart_busy", busy_cnt, 66);
    check("restart_done", done_cnt, 1);

    // Minimal configuration: one bit, half period 1, one latch cycle
    idle(80);
    set_en(1'b1);
    mon(2, 10, 1, 0, 8'h00);
    check("min_busy",   busy_cnt, 3);
    check("min_sclk",   int'(sclk_hist[2:0]), 'b010);
    check("min_bits",   int'(bits[0]), 1);
    check("min_nbits",  nbits, 1);
    check("min_latch",  latch_cnt, 1);
    check("min_done_t", (done_t.size() > 0) ? done_t[0] : -1, 4);

    idle(5);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/spio_status_led_shifter.md
SPIO_STATUS_LED_SHIFTER -- requirements
Module: spio_status_led_shifter

Interface
REQ-001 Parameter SHALL be NUM_DEVICES, default 8, number of LED bits per frame (>=1).
REQ-002 Parameter SHALL be HALF_PERIOD, default 4, CLK_IN cycles per SCLK phase (>=1).
REQ-003 Parameter SHALL be LATCH_CYCLES, default 2, CLK_IN cycles LATCH_OUT is held high (>=1).
REQ-004 Parameter SHALL be INVERT, default 0, 1 = drive inverted data for active-low LED drivers.
REQ-005 Port SHALL be CLK_IN  input  1  clock; all logic on rising edge.
REQ-006 Port SHALL be RESET_IN  input  1  reset, asynchronous, active-high.
REQ-007 Port SHALL be LED_IN  input  NUM_DEVICES  per-device LED state from the status LED generator.
REQ-008 Port SHALL be ENABLE_IN  input  1  request continuous frame refresh while high.
REQ-009 Port SHALL be SCLK_OUT  output  1  shift clock to external shift-register chain.
REQ-010 Port SHALL be SDATA_OUT  output  1  serial data, valid on SCLK_OUT rising edge.
REQ-011 Port SHALL be LATCH_OUT  output  1  storage-register latch strobe.
REQ-012 Port SHALL be BUSY_OUT  output  1  high while a frame is in progress.
REQ-013 Port SHALL be FRAME_DONE_OUT  output  1  one-cycle pulse at end of each frame.

Function
REQ-014 All outputs SHALL be registered (no combinational input-to-output paths).
REQ-015 FSM SHALL have states IDLE, SHIFT_LOW, SHIFT_HIGH, LATCH.
REQ-016 IDLE: if ENABLE_IN=1 at an edge, the block SHALL snapshot LED_IN (XOR {NUM_DEVICES{INVERT}}) into a shift register and enter SHIFT_LOW at that edge; otherwise remain IDLE.
REQ-017 LED_IN changes after the snapshot SHALL NOT affect the current frame.
REQ-018 Bit order SHALL be MSB first: LED_IN[NUM_DEVICES-1] first, LED_IN[0] last.
REQ-019 SHIFT_LOW: SCLK_OUT=0, SDATA_OUT=current bit, held exactly HALF_PERIOD cycles, then SHIFT_HIGH.
REQ-020 SHIFT_HIGH: SCLK_OUT=1, SDATA_OUT unchanged, held exactly HALF_PERIOD cycles; on exit the bit counter SHALL increment and the register shift by one.
REQ-021 After SHIFT_HIGH of bit NUM_DEVICES-1 the FSM SHALL enter LATCH; otherwise SHIFT_LOW with next bit.
REQ-022 LATCH: SCLK_OUT=0, SDATA_OUT=0, LATCH_OUT=1 for exactly LATCH_CYCLES cycles, then IDLE.
REQ-023 BUSY_OUT SHALL be high in SHIFT_LOW, SHIFT_HIGH, LATCH: exactly 2*HALF_PERIOD*NUM_DEVICES+LATCH_CYCLES cycles per frame.
REQ-024 FRAME_DONE_OUT SHALL be high for exactly the first IDLE cycle after LATCH.
REQ-025 With ENABLE_IN held high, frames SHALL repeat with exactly one IDLE cycle (BUSY_OUT low, FRAME_DONE_OUT high) between frames.
REQ-026 ENABLE_IN deasserted mid-frame SHALL NOT abort the frame; the frame completes including LATCH and FRAME_DONE_OUT.
REQ-027 Phase counter width SHALL be clog2(HALF_PERIOD+1), bit counter clog2(NUM_DEVICES+1); neither SHALL wrap within a frame.
REQ-028 HALF_PERIOD=1 SHALL yield SCLK_OUT toggling every cycle with no lost bits.

Reset
REQ-029 RESET_IN high SHALL immediately force state IDLE, SCLK_OUT=0, SDATA_OUT=0, LATCH_OUT=0, BUSY_OUT=0, FRAME_DONE_OUT=0, counters and shift register to 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no LATCH_OUT or FRAME_DONE_OUT pulse.
REQ-031 After RESET_IN falls, the first frame SHALL start at the first edge with ENABLE_IN=1.

Verification
REQ-032 Defaults, LED_IN=8'hA5, ENABLE_IN pulsed one cycle -> SDATA_OUT sampled at 8 SCLK rises = 1,0,1,0,0,1,0,1; BUSY_OUT high 66 cycles; LATCH_OUT high 2 cycles; one FRAME_DONE_OUT pulse; then idle.
REQ-033 ENABLE_IN held high 3 frames -> BUSY_OUT high 66, low 1, repeated; FRAME_DONE_OUT pulses spaced 67 cycles.
REQ-034 INVERT=1, LED_IN=8'hFF -> all 8 sampled bits 0.
REQ-035 LED_IN changed 8'h00->8'hFF during bit 3 -> frame shifts all zeros; next frame all ones.
REQ-036 RESET_IN asserted during bit 5 -> all outputs 0 same cycle, no LATCH_OUT/FRAME_DONE_OUT; after release, new frame starts cleanly.
REQ-037 HALF_PERIOD=1, NUM_DEVICES=1, LATCH_CYCLES=1, LED_IN=1 -> BUSY_OUT high 3 cycles, SCLK_OUT 0,1, SDATA_OUT=1, LATCH_OUT 1 cycle.
